df_serial_add_ctrl: RTL

//  Bit-serial add sequencer for the digital filter datapath. Accepts two WIDTH-bit

---
 rtl/df_serial_add_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/df_serial_add_ctrl.sv
// rtl/df_serial_add_ctrl.sv - bit-serial add sequencer driving one external full adder
//
// Purpose
//   Accepts two WIDTH-bit operands over a valid/ready handshake, walks them
//   LSB-first through a single external df_fulladder (one bit per cycle, carry
//   kept in a flop between steps) and returns the WIDTH-bit sum and carry-out
//   over a second valid/ready handshake.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_ready is high only when idle
//   in_a, in_b            unsigned operands, held by the source until accepted
//   in_sub                (DF_SERIAL_ADD_SUB_EN only) subtract in_b from in_a
//   out_valid/out_ready   result handshake; result held while out_ready is low
//   out_sum, out_co       result bits and final carry-out
//   fa_a, fa_b, fa_ci     to the external full adder, zero outside RUN
//   fa_s, fa_co           from the external full adder
//
// Configuration
//   DF_SERIAL_ADD_SUB_EN  adds in_sub; subtract is a + ~b + 1 with the carry
//                         flop preset to 1, so out_co=1 means no borrow.

module df_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef DF_SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             b_bit;
  logic             carry_init;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef DF_SERIAL_ADD_SUB_EN
  logic sub_q;

  // Subtract feeds the inverted B bit; the +1 comes from the preset carry.
  assign b_bit      = b_sh[0] ^ sub_q;
  assign carry_init = in_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      sub_q <= in_sub;
    end
  end
`else
  assign b_bit      = b_sh[0];
  assign carry_init = 1'b0;
`endif

  // The result registers double as the output: they only change in RUN, so
  // they are naturally stable for the whole of DONE.
  assign out_sum = sum_sh;
  assign out_co  = carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        fa_a  = a_sh[0];
        fa_b  = b_bit;
        fa_ci = carry;
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= carry_init;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_co;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          // Hold on the last bit so the counter never wraps for power-of-two WIDTH.
          if (!last_bit) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
